prog_load_dump: RTL

PROG_LOAD_DUMP -- requirements
Module: prog_load_dump

---
 rtl/prog_load_dump.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/prog_load_dump.sv
// Program loader/dumper: streams a program into core memory, lets the core run for a fixed
// number of clocks, then dumps the register file followed by the low memory words.
`timescale 1ns / 1ps
module prog_load_dump #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LOAD_BYTES = 64,
  parameter int unsigned RUN_CYCLES = 100,
  parameter int unsigned NREG       = 16,
  parameter int unsigned DUMP_WORDS = 64
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Start,
  input  logic [7:0]              In_data,
  input  logic                    In_valid,
  output logic                    In_ready,
  output logic                    Mem_we,
  output logic                    Mem_re,
  output logic [ADDR_W-1:0]       Mem_addr,
  output logic [7:0]              Mem_wdata,
  input  logic [DATA_W-1:0]       Mem_rdata,
  output logic                    Reg_re,
  output logic [$clog2(NREG)-1:0] Reg_addr,
  input  logic [DATA_W-1:0]       Reg_rdata,
  output logic                    Core_Reset,
  output logic                    Core_Halt,
  output logic [DATA_W-1:0]       Out_data,
  output logic                    Out_tag,
  output logic                    Out_valid,
  input  logic                    Out_ready,
  output logic                    Busy,
  output logic                    Done
);

  localparam int unsigned RegAw        = $clog2(NREG);
  localparam int unsigned BytesPerWord = DATA_W / 8;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDreg, StDmem, StDone} state_e;

  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              reg_re_q, reg_re_d;
  logic [RegAw-1:0]  reg_addr_q, reg_addr_d;
  logic              core_reset_q, core_reset_d;
  logic              core_halt_q, core_halt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_tag_q, out_tag_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rvalid_q, rvalid_d;

  logic beat, hs, issue;

  assign beat  = (state_q == StLoad) && In_valid && in_ready_q;
  assign hs    = out_valid_q && Out_ready;
  // A new read goes out on DREG entry and after every accepted dump beat that is not the last.
  assign issue = ((state_d == StDreg) && ((state_q == StRun) || hs)) ||
                 ((state_d == StDmem) && hs);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (beat) begin
          if (cnt_q == LOAD_BYTES - 1) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      StRun: begin
        if (cnt_q == RUN_CYCLES - 1) begin
          state_d = StDreg;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDreg: begin
        if (hs) begin
          if (cnt_q == NREG - 1) begin
            state_d = StDmem;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      StDmem: begin
        if (hs) begin
          if (cnt_q == DUMP_WORDS - 1) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_d   = (state_d == StLoad);
    // Core is held in reset whenever it is not running, so its reset is low only for RUN.
    core_reset_d = (state_d != StRun);
    core_halt_d  = (state_d == StDreg) || (state_d == StDmem) || (state_d == StDone);
    busy_d       = (state_d == StLoad) || (state_d == StRun) ||
                   (state_d == StDreg) || (state_d == StDmem);
    done_d       = (state_d == StDone);

    mem_we_d    = beat;
    mem_wdata_d = beat ? In_data : mem_wdata_q;
    mem_addr_d  = mem_addr_q;
    reg_addr_d  = reg_addr_q;
    mem_re_d    = 1'b0;
    reg_re_d    = 1'b0;
    if (beat) mem_addr_d = ADDR_W'(cnt_q);
    if (issue) begin
      if (state_d == StDreg) begin
        reg_re_d   = 1'b1;
        reg_addr_d = RegAw'(cnt_d);
      end else begin
        mem_re_d   = 1'b1;
        mem_addr_d = ADDR_W'(cnt_d * BytesPerWord);
      end
    end

    rvalid_d    = reg_re_q || mem_re_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    if (rvalid_q) begin
      out_valid_d = 1'b1;
      out_tag_d   = (state_q == StDmem);
      out_data_d  = (state_q == StDmem) ? Mem_rdata : Reg_rdata;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      reg_re_q     <= 1'b0;
      reg_addr_q   <= '0;
      core_reset_q <= 1'b1;
      core_halt_q  <= 1'b0;
      out_data_q   <= '0;
      out_tag_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      reg_re_q     <= reg_re_d;
      reg_addr_q   <= reg_addr_d;
      core_reset_q <= core_reset_d;
      core_halt_q  <= core_halt_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign In_ready   = in_ready_q;
  assign Mem_we     = mem_we_q;
  assign Mem_re     = mem_re_q;
  assign Mem_addr   = mem_addr_q;
  assign Mem_wdata  = mem_wdata_q;
  assign Reg_re     = reg_re_q;
  assign Reg_addr   = reg_addr_q;
  assign Core_Reset = core_reset_q;
  assign Core_Halt  = core_halt_q;
  assign Out_data   = out_data_q;
  assign Out_tag    = out_tag_q;
  assign Out_valid  = out_valid_q;
  assign Busy       = busy_q;
  assign Done       = done_q;

endmodule
